// File: rtl/guess_game_pkg.sv
// rtl/guess_game_pkg.sv - shared timing constants, button indices and repeat FSM states
package guess_game_pkg;
   localparam int DEBOUNCE_50M     = 1_000_000;
   localparam int REPEAT_DELAY_50M = 25_000_000;
   localparam int REPEAT_RATE_50M  = 10_000_000;

   localparam int BTN_START  = 0;
   localparam int BTN_INC    = 1;
   localparam int BTN_SUBMIT = 2;

   typedef enum logic [1:0] {IDLE, DELAY, RATE} rpt_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: synchroniser, debounce, edge strobes, auto-repeat
module button_channel
   import guess_game_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_50M,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_50M,
   parameter int REPEAT_RATE     = REPEAT_RATE_50M,
   parameter bit REPEAT_EN       = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic repeat_o
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RP_W = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
   logic                   db_q, db_d;
   logic                   db_dly_q;
   rpt_state_e             state_q, state_d;
   logic [RP_W-1:0]        rp_cnt_q, rp_cnt_d;
   logic                   rep_fsm;

   assign sync = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q   <= '0;
         db_cnt_q <= '0;
         db_q     <= 1'b0;
         db_dly_q <= 1'b0;
         state_q  <= IDLE;
         rp_cnt_q <= '0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
         db_cnt_q <= db_cnt_d;
         db_q     <= db_d;
         db_dly_q <= db_q;
         state_q  <= state_d;
         rp_cnt_q <= rp_cnt_d;
      end
   end

   // Any matching cycle drops the count, so only an unbroken run of mismatches flips db.
   always_comb begin
      db_cnt_d = '0;
      db_d     = db_q;
      if (sync != db_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) db_d = sync;
         else                                        db_cnt_d = db_cnt_q + 1'b1;
      end
   end

   assign level_o   = db_q;
   assign press_o   = db_q & ~db_dly_q;
   assign release_o = ~db_q & db_dly_q;

   always_comb begin
      state_d  = state_q;
      rp_cnt_d = rp_cnt_q;
      rep_fsm  = 1'b0;
      if (!db_q) begin
         state_d  = IDLE;
         rp_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: if (press_o) begin
               rep_fsm  = 1'b1;
               rp_cnt_d = '0;
               state_d  = DELAY;
            end
            DELAY: if (rp_cnt_q == RP_W'(REPEAT_DELAY - 1)) begin
               rep_fsm  = 1'b1;
               rp_cnt_d = '0;
               state_d  = RATE;
            end else begin
               rp_cnt_d = rp_cnt_q + 1'b1;
            end
            RATE: if (rp_cnt_q == RP_W'(REPEAT_RATE - 1)) begin
               rep_fsm  = 1'b1;
               rp_cnt_d = '0;
            end else begin
               rp_cnt_d = rp_cnt_q + 1'b1;
            end
            default: begin
               state_d  = IDLE;
               rp_cnt_d = '0;
            end
         endcase
      end
   end

   assign repeat_o = REPEAT_EN ? rep_fsm : press_o;
endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - conditions the raw game buttons into clean level and strobe outputs
module button_conditioner
   import guess_game_pkg::*;
#(
   parameter int               N_BTN           = 3,
   parameter int               SYNC_STAGES     = 2,
   parameter int               DEBOUNCE_CYCLES = DEBOUNCE_50M,
   parameter int               REPEAT_DELAY    = REPEAT_DELAY_50M,
   parameter int               REPEAT_RATE     = REPEAT_RATE_50M,
   parameter logic [N_BTN-1:0] REPEAT_MASK     = 3'b010
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat
);
   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      button_channel #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_RATE    (REPEAT_RATE),
         .REPEAT_EN      (REPEAT_MASK[i])
      ) u_ch (
         .clk      (clk),
         .reset_n  (reset_n),
         .raw_i    (btn_raw[i]),
         .level_o  (btn_level[i]),
         .press_o  (btn_press[i]),
         .release_o(btn_release[i]),
         .repeat_o (btn_repeat[i])
      );
   end
endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized and directed bench for button_conditioner
module tb_button_conditioner;
   localparam int N = 3, SYNC = 2, DB = 8, RD = 20, RR = 5;
   localparam logic [2:0] MASK = 3'b010;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [2:0] btn_raw = 3'b000;
   logic [2:0] btn_level, btn_press, btn_release, btn_repeat;

   button_conditioner #(
      .N_BTN(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DB),
      .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .REPEAT_MASK(MASK)
   ) dut (
      .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
      .btn_level(btn_level), .btn_press(btn_press),
      .btn_release(btn_release), .btn_repeat(btn_repeat)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0, cyc = 0;
   int press_cnt[N], rel_cnt[N], rep_cnt[N], press_cyc[N], rel_cyc[N];
   logic [2:0] mask_v = MASK;

   // reference: raw delay line, mismatch run length, and time held since acceptance
   logic [2:0] m_pipe[SYNC];
   logic [2:0] m_db, m_db_prev;
   int         m_run[N], m_age[N];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at cycle %0d: got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic bit rep_due(input int a);
      return (a == 0) || (a == RD) || (a > RD && ((a - RD) % RR) == 0);
   endfunction

   task automatic model_reset();
      for (int s = 0; s < SYNC; s++) m_pipe[s] = '0;
      m_db = '0;
      m_db_prev = '0;
      for (int c = 0; c < N; c++) begin
         m_run[c] = 0;
         m_age[c] = 0;
      end
   endtask

   task automatic model_clock();
      logic [2:0] nd;
      nd = m_db;
      for (int c = 0; c < N; c++) begin
         if (m_pipe[SYNC-1][c] != m_db[c]) begin
            m_run[c]++;
            if (m_run[c] == DB) begin
               nd[c] = m_pipe[SYNC-1][c];
               m_run[c] = 0;
            end
         end else begin
            m_run[c] = 0;
         end
      end
      for (int s = SYNC - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
      m_pipe[0] = btn_raw;
      for (int c = 0; c < N; c++) m_age[c] = (nd[c] && m_db[c]) ? m_age[c] + 1 : 0;
      m_db_prev = m_db;
      m_db = nd;
   endtask

   task automatic clear_counts();
      for (int c = 0; c < N; c++) begin
         press_cnt[c] = 0; rel_cnt[c] = 0; rep_cnt[c] = 0;
         press_cyc[c] = -1; rel_cyc[c] = -1;
      end
   endtask

   task automatic tick();
      logic [2:0] e_press, e_rel, e_rep;
      @(posedge clk);
      cyc++;
      if (!reset_n) model_reset();
      else model_clock();
      #1;
      e_press = m_db & ~m_db_prev;
      e_rel   = ~m_db & m_db_prev;
      for (int c = 0; c < N; c++)
         e_rep[c] = mask_v[c] ? (m_db[c] && rep_due(m_age[c])) : e_press[c];
      check_eq("level",   btn_level,   m_db);
      check_eq("press",   btn_press,   e_press);
      check_eq("release", btn_release, e_rel);
      check_eq("repeat",  btn_repeat,  e_rep);
      for (int c = 0; c < N; c++) begin
         if (btn_press[c])   begin press_cnt[c]++; press_cyc[c] = cyc; end
         if (btn_release[c]) begin rel_cnt[c]++;   rel_cyc[c]   = cyc; end
         if (btn_repeat[c])  rep_cnt[c]++;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_press(input int ch);
      int n = 0;
      while (!btn_press[ch] && n < 30) begin
         tick();
         n++;
      end
      check_eq("press_seen", btn_press[ch], 1);
   endtask

   task automatic reset_async();
      reset_n = 1'b0;
      #1;
      check_eq("rst_level",   btn_level,   0);
      check_eq("rst_press",   btn_press,   0);
      check_eq("rst_release", btn_release, 0);
      check_eq("rst_repeat",  btn_repeat,  0);
      model_reset();
   endtask

   int t0, fall;
   int hold[N];

   initial begin
      model_reset();
      clear_counts();
      ticks(3);
      reset_n = 1'b1;
      ticks(3);

      // clean press on an unmasked channel
      clear_counts();
      btn_raw[2] = 1'b1;
      t0 = cyc;
      ticks(20);
      check_eq("t1_latency", press_cyc[2] - t0, 10);
      check_eq("t1_press_cnt", press_cnt[2], 1);
      check_eq("t1_repeat_cnt", rep_cnt[2], 1);
      check_eq("t1_level", btn_level[2], 1);

      // bounce rejection
      clear_counts();
      for (int k = 0; k < 4; k++) begin
         btn_raw[0] = 1'b1; ticks(5);
         btn_raw[0] = 1'b0; ticks(1);
      end
      ticks(10);
      check_eq("t2_no_press", press_cnt[0], 0);
      check_eq("t2_level", btn_level[0], 0);
      btn_raw[0] = 1'b1;
      ticks(12);
      check_eq("t2_one_press", press_cnt[0], 1);
      btn_raw = 3'b000;
      ticks(15);

      // auto-repeat on the held increment button
      clear_counts();
      btn_raw[1] = 1'b1;
      wait_press(1);
      ticks(60);
      btn_raw[1] = 1'b0;
      fall = cyc;
      ticks(15);
      check_eq("t3_repeats", rep_cnt[1], 11);
      check_eq("t3_release_cnt", rel_cnt[1], 1);
      check_eq("t3_release_lat", rel_cyc[1] - fall, 10);

      // db falls exactly when a rate repeat would be due
      clear_counts();
      btn_raw[1] = 1'b1;
      wait_press(1);
      ticks(20);
      btn_raw[1] = 1'b0;
      ticks(15);
      check_eq("t4_repeats", rep_cnt[1], 3);
      check_eq("t4_release_cnt", rel_cnt[1], 1);

      // simultaneous presses, then reset mid-hold
      clear_counts();
      btn_raw = 3'b111;
      t0 = cyc;
      ticks(12);
      for (int c = 0; c < N; c++) check_eq("t5_sim_lat", press_cyc[c] - t0, 10);
      ticks(7);
      reset_async();
      ticks(3);
      clear_counts();
      @(negedge clk);
      reset_n = 1'b1;
      t0 = cyc;
      ticks(14);
      for (int c = 0; c < N; c++) check_eq("t5_post_rst_lat", press_cyc[c] - t0, 10);
      check_eq("t5_no_release", rel_cnt[0] + rel_cnt[1] + rel_cnt[2], 0);

      // random phase
      for (int c = 0; c < N; c++) hold[c] = $urandom_range(1, 35);
      for (int i = 0; i < 1500; i++) begin
         for (int c = 0; c < N; c++) begin
            hold[c]--;
            if (hold[c] <= 0) begin
               btn_raw[c] = ~btn_raw[c];
               hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(7, 45);
            end
         end
         if ($urandom_range(0, 499) == 0) begin
            reset_async();
            tick();
            reset_n = 1'b1;
         end else begin
            tick();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
